// File: rtl/program_counter_if.sv
// Bundle of the next-PC / current-PC connection between the datapath and the PC register.
// The datapath drives reset and PCNext as master; the PC register is the slave.
interface program_counter_if #(
   parameter int WIDTH = 32
);
   logic             reset;
   logic [WIDTH-1:0] PCNext;
   logic [WIDTH-1:0] PC;

   modport master (output reset, output PCNext, input PC);
   modport slave  (input reset, input PCNext, output PC);
endinterface

// File: rtl/program_counter.sv
// Program-counter register for the single-cycle MIPS datapath.
// Captures PCNext each rising edge; synchronous reset loads the reset vector.
module program_counter #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic [WIDTH-1:0] PCNext,
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] PC
);

   // Header order is positional-compatible with existing instantiations.
   logic [WIDTH-1:0] pc_q;

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_VALUE;
      else       pc_q <= PCNext;
   end

   assign PC = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;
   localparam int WIDTH = 32;

   logic clk;
   int   checks;
   int   errors;

   program_counter_if #(.WIDTH(WIDTH)) pif ();

   program_counter #(.WIDTH(WIDTH), .RESET_VALUE(32'h0000_0000)) dut (
      .PCNext (pif.PCNext),
      .clk    (clk),
      .reset  (pif.reset),
      .PC     (pif.PC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      edge_settle();
      checks++;
      if (pif.PC !== 32'h0000_0000) begin
         errors++;
         $display("FAIL reset_first_edge PC=%h expected=%h", pif.PC, 32'h0);
      end
   endtask

   task automatic test_release();
      @(negedge clk);
      pif.reset  = 1'b0;
      pif.PCNext = 32'h0000_0000;
      edge_settle();
      checks++;
      if (pif.PC !== 32'h0000_0000) begin
         errors++;
         $display("FAIL release_first_load PC=%h expected=%h", pif.PC, 32'h0);
      end
      @(negedge clk);
      pif.PCNext = 32'h0000_0100;
      edge_settle();
      checks++;
      if (pif.PC !== 32'h0000_0100) begin
         errors++;
         $display("FAIL release_follow PC=%h expected=%h", pif.PC, 32'h100);
      end
   endtask

   task automatic test_reset_dominates();
      logic [31:0] vals [3];
      vals[0] = 32'h1234_5678;
      vals[1] = 32'h5678_1234;
      vals[2] = 32'hCAFE_F00C;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pif.reset  = 1'b1;
         pif.PCNext = vals[i];
         edge_settle();
         checks++;
         if (pif.PC !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_dominates[%0d] PC=%h expected=%h", i, pif.PC, 32'h0);
         end
      end
   endtask

   task automatic test_load_seq();
      logic [31:0] vals [3];
      logic [31:0] prev;
      vals[0] = 32'h0040_0000;
      vals[1] = 32'h0040_0004;
      vals[2] = 32'h0040_0024;
      prev    = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pif.reset  = 1'b0;
         pif.PCNext = vals[i];
         #1;
         // PCNext changed but no edge yet: PC must still hold the previous value.
         checks++;
         if (pif.PC !== prev) begin
            errors++;
            $display("FAIL load_hold[%0d] PC=%h expected=%h", i, pif.PC, prev);
         end
         edge_settle();
         checks++;
         if (pif.PC !== vals[i]) begin
            errors++;
            $display("FAIL load_seq[%0d] PC=%h expected=%h", i, pif.PC, vals[i]);
         end
         prev = vals[i];
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      pif.reset  = 1'b0;
      pif.PCNext = 32'hDEAD_BEE0;
      edge_settle();
      checks++;
      if (pif.PC !== 32'hDEAD_BEE0) begin
         errors++;
         $display("FAIL mid_reset_preload PC=%h expected=%h", pif.PC, 32'hDEADBEE0);
      end
      @(negedge clk);
      pif.reset  = 1'b1;
      pif.PCNext = 32'h0000_0010;
      edge_settle();
      checks++;
      if (pif.PC !== 32'h0000_0000) begin
         errors++;
         $display("FAIL mid_reset_clear PC=%h expected=%h", pif.PC, 32'h0);
      end
      @(negedge clk);
      pif.reset = 1'b0;
      edge_settle();
      checks++;
      if (pif.PC !== 32'h0000_0010) begin
         errors++;
         $display("FAIL mid_reset_resume PC=%h expected=%h", pif.PC, 32'h10);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      pif.PCNext = 32'h0000_0020;
      #1;
      pif.reset = 1'b1;
      #2;
      checks++;
      if (pif.PC !== 32'h0000_0010) begin
         errors++;
         $display("FAIL async_reset_ignored PC=%h expected=%h", pif.PC, 32'h10);
      end
      pif.reset = 1'b0;
      edge_settle();
      checks++;
      if (pif.PC !== 32'h0000_0020) begin
         errors++;
         $display("FAIL async_reset_load PC=%h expected=%h", pif.PC, 32'h20);
      end
   endtask

   task automatic test_full_width();
      logic [31:0] vals [3];
      vals[0] = 32'hFFFF_FFFF;
      vals[1] = 32'h0000_0003;
      vals[2] = 32'h8000_0001;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pif.reset  = 1'b0;
         pif.PCNext = vals[i];
         edge_settle();
         checks++;
         if (pif.PC !== vals[i]) begin
            errors++;
            $display("FAIL full_width[%0d] PC=%h expected=%h", i, pif.PC, vals[i]);
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      pif.reset  = 1'b1;
      pif.PCNext = 32'h0000_0000;
      test_reset();
      test_release();
      test_reset_dominates();
      test_load_seq();
      test_mid_reset();
      test_async_reset();
      test_full_width();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
